// File: rtl/pa_pkg.sv
// pa_pkg: shared constants and types for the PA memory/write-back stage.
//   DATA_W, REG_ADDR_W : datapath and register-index widths
//   LANES              : byte lanes per data word
//   mem_state_t        : FSM states of mem_writeback (IDLE, WAIT)
//   LANE0..LANE3       : byte-lane selectors (addr[1:0]); little-endian, lane 0 = bits [7:0]
package pa_pkg;
   localparam int DATA_W     = 32;
   localparam int REG_ADDR_W = 5;
   localparam int LANES      = DATA_W / 8;

   typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} mem_state_t;

   localparam logic [1:0] LANE0 = 2'd0;
   localparam logic [1:0] LANE1 = 2'd1;
   localparam logic [1:0] LANE2 = 2'd2;
   localparam logic [1:0] LANE3 = 2'd3;
endpackage

// File: rtl/mem_writeback_if.sv
// mem_writeback_if: single-outstanding request/ready bus between the
// memory/write-back stage (master) and the cache/MMU (slave).
//   mem_req   : request valid          mem_we    : store
//   mem_byte  : byte access            mem_addr  : access address
//   mem_wdata : store data             mem_ready : access complete (rdata valid same cycle)
//   mem_rdata : load data
interface mem_writeback_if;
   import pa_pkg::*;

   logic              mem_req;
   logic              mem_we;
   logic              mem_byte;
   logic [DATA_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ready;
   logic [DATA_W-1:0] mem_rdata;

   modport master (output mem_req, mem_we, mem_byte, mem_addr, mem_wdata,
                   input  mem_ready, mem_rdata);
   modport slave  (input  mem_req, mem_we, mem_byte, mem_addr, mem_wdata,
                   output mem_ready, mem_rdata);
endinterface

// File: rtl/load_align.sv
// load_align: combinational load-data alignment.
//   rdata    : raw word from the cache
//   addr     : low address bits, select the byte lane for byte loads
//   byte_sel : 1 = byte load, 0 = word load (rdata passed through)
//   data     : aligned, extended result
// Macro LOAD_SIGN_EXTEND_EN: byte loads sign-extend from bit 7; otherwise zero-extend.
module load_align
   import pa_pkg::*;
(
   input  logic [DATA_W-1:0] rdata,
   input  logic [1:0]        addr,
   input  logic              byte_sel,
   output logic [DATA_W-1:0] data
);
   logic [LANES-1:0][7:0] lanes;
   logic [7:0]            lane;
   logic [DATA_W-1:0]     ext;

   assign lanes = rdata;

   always_comb begin
      lane = lanes[LANE0];
      case (addr)
         LANE1:   lane = lanes[LANE1];
         LANE2:   lane = lanes[LANE2];
         LANE3:   lane = lanes[LANE3];
         default: lane = lanes[LANE0];
      endcase
   end

`ifdef LOAD_SIGN_EXTEND_EN
   assign ext = {{(DATA_W-8){lane[7]}}, lane};
`else
   assign ext = {{(DATA_W-8){1'b0}}, lane};
`endif

   assign data = byte_sel ? ext : rdata;
endmodule

// File: rtl/mem_writeback.sv
// mem_writeback: memory-access and write-back stage of the PA pipeline.
// Accepts the EX/MEM bundle, runs one outstanding cache/MMU access at a time
// and emits a registered one-cycle write-back pulse to Decode.
//   clk, reset      : clock, asynchronous active-low reset
//   ex_*            : EX/MEM bundle (valid, ALU result/address, store data,
//                     destination, read/write/byte flags, register-write flag)
//   stall_out       : hold EX/MEM and earlier stages
//   mem             : request/ready bus to the cache (master side)
//   addr_d_out, d_out, write_out : write-back bundle to Decode
// Macro LOAD_SIGN_EXTEND_EN (in load_align): sign-extend byte loads.
module mem_writeback
   import pa_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ex_valid,
   input  logic [DATA_W-1:0]     ex_alu_result,
   input  logic [DATA_W-1:0]     ex_store_data,
   input  logic [REG_ADDR_W-1:0] ex_addr_d,
   input  logic                  ex_read_mmu,
   input  logic                  ex_write_mmu,
   input  logic                  ex_byte_select_mmu,
   input  logic                  ex_write_out,
   output logic                  stall_out,
   mem_writeback_if.master       mem,
   output logic [REG_ADDR_W-1:0] addr_d_out,
   output logic [DATA_W-1:0]     d_out,
   output logic                  write_out
);
   mem_state_t            state, state_nx;
   logic [DATA_W-1:0]     cap_addr, cap_wdata, load_data;
   logic [REG_ADDR_W-1:0] cap_rd;
   logic                  cap_we, cap_byte, cap_wr;
   logic                  is_mem, accept_mem;

   assign is_mem     = ex_read_mmu | ex_write_mmu;
   assign accept_mem = (state == IDLE) && ex_valid && is_mem;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept_mem) state_nx = WAIT;
         WAIT:    if (mem.mem_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Capture registers; store data is lane-replicated up front for byte stores.
   // A set write flag makes the access a store even if read is also set.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cap_addr  <= '0;
         cap_wdata <= '0;
         cap_rd    <= '0;
         cap_we    <= 1'b0;
         cap_byte  <= 1'b0;
         cap_wr    <= 1'b0;
      end else if (accept_mem) begin
         cap_addr  <= ex_alu_result;
         cap_wdata <= ex_byte_select_mmu ? {LANES{ex_store_data[7:0]}} : ex_store_data;
         cap_rd    <= ex_addr_d;
         cap_we    <= ex_write_mmu;
         cap_byte  <= ex_byte_select_mmu;
         cap_wr    <= ex_write_out;
      end
   end

   load_align u_align (
      .rdata    (mem.mem_rdata),
      .addr     (cap_addr[1:0]),
      .byte_sel (cap_byte),
      .data     (load_data)
   );

   // Write-back bundle: write_out defaults low so it only ever pulses.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         write_out  <= 1'b0;
         d_out      <= '0;
         addr_d_out <= '0;
      end else begin
         write_out <= 1'b0;
         if (state == IDLE) begin
            if (ex_valid && !is_mem) begin
               write_out  <= ex_write_out;
               d_out      <= ex_alu_result;
               addr_d_out <= ex_addr_d;
            end
         end else if (mem.mem_ready && !cap_we) begin
            write_out  <= cap_wr;
            d_out      <= load_data;
            addr_d_out <= cap_rd;
         end
      end
   end

   assign mem.mem_req   = (state == WAIT);
   assign mem.mem_we    = cap_we;
   assign mem.mem_byte  = cap_byte;
   assign mem.mem_addr  = cap_addr;
   assign mem.mem_wdata = cap_wdata;
   assign stall_out     = (state == WAIT) && !mem.mem_ready;
endmodule

// File: tb/tb_mem_writeback.sv
// tb_mem_writeback: directed bench for mem_writeback with a transaction-level
// reference model checked every cycle plus hand-computed literal checks.
module tb_mem_writeback;
   logic        clk, reset;
   logic        ex_valid, ex_read_mmu, ex_write_mmu, ex_byte_select_mmu, ex_write_out;
   logic [31:0] ex_alu_result, ex_store_data, d_out;
   logic [4:0]  ex_addr_d, addr_d_out;
   logic        stall_out, write_out;
   int          nvec, nerr, nst;
   bit          run;

   mem_writeback_if mif();

   mem_writeback dut (
      .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_alu_result(ex_alu_result),
      .ex_store_data(ex_store_data), .ex_addr_d(ex_addr_d), .ex_read_mmu(ex_read_mmu),
      .ex_write_mmu(ex_write_mmu), .ex_byte_select_mmu(ex_byte_select_mmu),
      .ex_write_out(ex_write_out), .stall_out(stall_out), .mem(mif),
      .addr_d_out(addr_d_out), .d_out(d_out), .write_out(write_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected load result from the lane rules, written as shifts and masks.
   function automatic logic [31:0] exp_load(input logic [31:0] a, input logic [31:0] rd,
                                            input logic b);
      logic [31:0] v;
      int          sh;
      if (!b) return rd;
      sh = int'(a[1:0]) * 8;
      v  = (rd >> sh) & 32'h0000_00FF;
`ifdef LOAD_SIGN_EXTEND_EN
      if (v[7]) v = v | 32'hFFFF_FF00;
`endif
      return v;
   endfunction

   // Reference model: at most one outstanding memory op; write-back bundle
   // values expected after each edge.
   bit          m_busy, m_we, m_byt, m_wr, m_wo;
   logic [31:0] m_addr, m_sd, m_d;
   logic [4:0]  m_rdst, m_rd;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_busy <= 0; m_wo <= 0; m_d <= '0; m_rd <= '0;
      end else if (m_busy) begin
         m_wo <= 0;
         if (mif.mem_ready) begin
            m_busy <= 0;
            if (!m_we) begin
               m_wo <= m_wr;
               m_d  <= exp_load(m_addr, mif.mem_rdata, m_byt);
               m_rd <= m_rdst;
            end
         end
      end else if (ex_valid && (ex_read_mmu || ex_write_mmu)) begin
         m_busy <= 1; m_wo <= 0;
         m_addr <= ex_alu_result; m_sd <= ex_store_data; m_rdst <= ex_addr_d;
         m_we <= ex_write_mmu; m_byt <= ex_byte_select_mmu; m_wr <= ex_write_out;
      end else if (ex_valid) begin
         m_wo <= ex_write_out; m_d <= ex_alu_result; m_rd <= ex_addr_d;
      end else begin
         m_wo <= 0;
      end
   end

   always @(negedge clk) begin
      if (run) begin
         chk("write_out", {31'd0, write_out}, {31'd0, m_wo});
         chk("addr_d_out", {27'd0, addr_d_out}, {27'd0, m_rd});
         chk("d_out", d_out, m_d);
         chk("mem_req", {31'd0, mif.mem_req}, {31'd0, m_busy});
         chk("stall_out", {31'd0, stall_out}, {31'd0, m_busy && !mif.mem_ready});
         if (m_busy) begin
            chk("mem_we", {31'd0, mif.mem_we}, {31'd0, m_we});
            chk("mem_byte", {31'd0, mif.mem_byte}, {31'd0, m_byt});
            chk("mem_addr", mif.mem_addr, m_addr);
            chk("mem_wdata", mif.mem_wdata, m_byt ? m_sd[7:0] * 32'h0101_0101 : m_sd);
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ex(input logic v, input logic [31:0] alu, input logic [31:0] sd,
                         input logic [4:0] rd, input logic r, input logic w,
                         input logic b, input logic wo);
      ex_valid = v; ex_alu_result = alu; ex_store_data = sd; ex_addr_d = rd;
      ex_read_mmu = r; ex_write_mmu = w; ex_byte_select_mmu = b; ex_write_out = wo;
   endtask

   initial begin
      nvec = 0; nerr = 0; nst = 0; run = 0;
      set_ex(0, 0, 0, 0, 0, 0, 0, 0);
      mif.mem_ready = 0; mif.mem_rdata = '0;
      reset = 1;
      #1 reset = 0;
      #2;
      // Reset values
      chk("rst write_out", {31'd0, write_out}, 32'd0);
      chk("rst d_out", d_out, 32'd0);
      chk("rst addr_d_out", {27'd0, addr_d_out}, 32'd0);
      chk("rst mem_req", {31'd0, mif.mem_req}, 32'd0);
      chk("rst mem_we", {31'd0, mif.mem_we}, 32'd0);
      chk("rst mem_byte", {31'd0, mif.mem_byte}, 32'd0);
      chk("rst mem_addr", mif.mem_addr, 32'd0);
      chk("rst mem_wdata", mif.mem_wdata, 32'd0);
      chk("rst stall_out", {31'd0, stall_out}, 32'd0);
      cyc(); cyc();
      reset = 1; run = 1;

      // ALU op, rd=5
      set_ex(1, 32'h0000_1234, 0, 5, 0, 0, 0, 1);
      cyc();
      set_ex(0, 0, 0, 0, 0, 0, 0, 0);
      chk("alu wo", {31'd0, write_out}, 32'd1);
      chk("alu rd", {27'd0, addr_d_out}, 32'd5);
      chk("alu d", d_out, 32'h0000_1234);
      chk("alu stall", {31'd0, stall_out}, 32'd0);
      cyc();
      chk("alu pulse", {31'd0, write_out}, 32'd0);

      // Word load from 0x100, ready after 3 WAIT cycles
      set_ex(1, 32'h100, 0, 7, 1, 0, 0, 1);
      cyc();
      set_ex(0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         if (stall_out) nst++;
         cyc();
      end
      mif.mem_ready = 1; mif.mem_rdata = 32'hDEAD_BEEF;
      #1 if (stall_out) nst++;
      cyc();
      mif.mem_ready = 0;
      chk("stall cycles", nst, 32'd3);
      chk("ld wo", {31'd0, write_out}, 32'd1);
      chk("ld rd", {27'd0, addr_d_out}, 32'd7);
      chk("ld d", d_out, 32'hDEAD_BEEF);
      cyc();
      chk("ld pulse", {31'd0, write_out}, 32'd0);

      // Byte load from 0x103, ready in first WAIT cycle
      set_ex(1, 32'h103, 0, 4, 1, 0, 1, 1);
      cyc();
      set_ex(0, 0, 0, 0, 0, 0, 0, 0);
      mif.mem_ready = 1; mif.mem_rdata = 32'h80AA_BBCC;
      cyc();
      mif.mem_ready = 0;
      chk("lb wo", {31'd0, write_out}, 32'd1);
`ifdef LOAD_SIGN_EXTEND_EN
      chk("lb d", d_out, 32'hFFFF_FF80);
`else
      chk("lb d", d_out, 32'h0000_0080);
`endif
      cyc();

      // Byte store of 0x12345678 to 0x41
      set_ex(1, 32'h41, 32'h1234_5678, 2, 0, 1, 1, 1);
      cyc();
      set_ex(0, 0, 0, 0, 0, 0, 0, 0);
      chk("sb req", {31'd0, mif.mem_req}, 32'd1);
      chk("sb we", {31'd0, mif.mem_we}, 32'd1);
      chk("sb byte", {31'd0, mif.mem_byte}, 32'd1);
      chk("sb addr", mif.mem_addr, 32'h41);
      chk("sb wdata", mif.mem_wdata, 32'h7878_7878);
      cyc();
      mif.mem_ready = 1;
      cyc();
      mif.mem_ready = 0;
      chk("sb wo", {31'd0, write_out}, 32'd0);

      // Read and write both set: store, word
      set_ex(1, 32'h80, 32'hCAFE_F00D, 6, 1, 1, 0, 1);
      cyc();
      set_ex(0, 0, 0, 0, 0, 0, 0, 0);
      chk("rw we", {31'd0, mif.mem_we}, 32'd1);
      chk("rw wdata", mif.mem_wdata, 32'hCAFE_F00D);
      mif.mem_ready = 1; mif.mem_rdata = 32'h1111_1111;
      cyc();
      chk("rw wo", {31'd0, write_out}, 32'd0);

      // mem_ready while idle is ignored; non-writing ALU op
      set_ex(1, 32'h999, 0, 8, 0, 0, 0, 0);
      cyc();
      mif.mem_ready = 0;
      set_ex(0, 0, 0, 0, 0, 0, 0, 0);
      chk("nw wo", {31'd0, write_out}, 32'd0);
      chk("nw d", d_out, 32'h999);

      // Back-to-back: load then ALU op held in EX/MEM
      set_ex(1, 32'h200, 0, 3, 1, 0, 0, 1);
      cyc();
      set_ex(1, 32'hABCD, 0, 9, 0, 0, 0, 1);
      cyc();
      mif.mem_ready = 1; mif.mem_rdata = 32'h0000_0055;
      cyc();
      mif.mem_ready = 0;
      chk("b2b ld wo", {31'd0, write_out}, 32'd1);
      chk("b2b ld rd", {27'd0, addr_d_out}, 32'd3);
      chk("b2b ld d", d_out, 32'h55);
      cyc();
      set_ex(0, 0, 0, 0, 0, 0, 0, 0);
      chk("b2b alu wo", {31'd0, write_out}, 32'd1);
      chk("b2b alu rd", {27'd0, addr_d_out}, 32'd9);
      chk("b2b alu d", d_out, 32'hABCD);
      cyc();
      chk("b2b no dup", {31'd0, write_out}, 32'd0);

      // Reset during WAIT
      set_ex(1, 32'h300, 0, 10, 1, 0, 0, 1);
      cyc();
      set_ex(0, 0, 0, 0, 0, 0, 0, 0);
      #2 reset = 0;
      #1;
      chk("rst req drop", {31'd0, mif.mem_req}, 32'd0);
      chk("rst stall", {31'd0, stall_out}, 32'd0);
      cyc();
      reset = 1;
      cyc();
      chk("post rst wo", {31'd0, write_out}, 32'd0);
      set_ex(1, 32'h77, 0, 1, 0, 0, 0, 1);
      cyc();
      set_ex(0, 0, 0, 0, 0, 0, 0, 0);
      chk("post rst alu wo", {31'd0, write_out}, 32'd1);
      chk("post rst alu d", d_out, 32'h77);
      chk("post rst alu rd", {27'd0, addr_d_out}, 32'd1);
      cyc(); cyc();
      run = 0;

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule

// File: doc/mem_writeback.md
# mem_writeback

Memory-access and write-back stage of the PA pipeline: the return path that produces the register-file write bundle consumed by Decode. It takes the EX/MEM bundle (ALU result, store data, destination register, mmu read/write/byte flags, register-write flag) and drives a single-outstanding request/ready handshake to the cache/MMU. For each instruction it emits one registered write-back pulse, `addr_d_out`/`d_out`/`write_out`, which feeds Decode's `addr_d_in`/`d_in`/`write_in`. It stalls upstream while a memory access is outstanding.

## Interface
- No parameters. Widths are fixed by package constants.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `ex_valid` in 1: EX/MEM bundle holds a real instruction.
- `ex_alu_result` in 32: ALU result, or effective address for loads and stores.
- `ex_store_data` in 32: src2 value to be stored.
- `ex_addr_d` in 5: destination register.
- `ex_read_mmu` / `ex_write_mmu` / `ex_byte_select_mmu` in 1 each: load, store, byte (1) or word (0) access.
- `ex_write_out` in 1: instruction writes a register.
- `stall_out` out 1: hold the EX/MEM bundle and all earlier stages.
- `mem_req` out 1: request valid.
- `mem_we` out 1: store.
- `mem_byte` out 1: byte access.
- `mem_addr` out 32: access address.
- `mem_wdata` out 32: store data.
- `mem_ready` in 1: access complete; `mem_rdata` is valid in the same cycle.
- `mem_rdata` in 32: load data.
- `addr_d_out` out 5, `d_out` out 32, `write_out` out 1: registered write-back bundle to Decode.

## Operation
- FSM has 2 states: IDLE and WAIT. Reset state is IDLE.
- IDLE, `ex_valid`=1, neither read nor write flag set: at the next edge the write-back bundle is loaded with `ex_write_out`, `ex_alu_result` and `ex_addr_d`. The FSM stays in IDLE.
- IDLE, `ex_valid`=1, read or write flag set:
  - At the next edge, capture address, store data, destination, read/write/byte flags and the write flag.
  - Go to WAIT.
  - Load `write_out` with 0.
- IDLE, `ex_valid`=0: `write_out` becomes 0 at the next edge.
- WAIT:
  - `mem_req`=1, driven from the state register.
  - `mem_addr`, `mem_we` and `mem_byte` come from the captured registers.
  - EX/MEM inputs are ignored.
- WAIT with `mem_ready`=1: at the next edge return to IDLE.
  - Load: `write_out`=captured write flag, `d_out`=aligned load data, `addr_d_out`=captured destination.
  - Store: `write_out`=0.
- If read and write are both set, the instruction is treated as a store.
- Byte load: `addr[1:0]` selects the lane, little-endian; lane 0 is `rdata[7:0]`. The lane is extended to 32 bits as set in Configuration.
- Word load: `rdata` is used unchanged. No alignment check is made; the cache owns alignment.
- Byte store: `mem_wdata` = `store_data[7:0]` replicated in all 4 lanes.
- Word store: `mem_wdata` = `store_data`.
- Register 0 writes are not filtered here; the register bank owns that rule.

## Timing
- Reset values: FSM in IDLE; `write_out`, `d_out`, `addr_d_out`, `mem_req`, `mem_we`, `mem_byte`, `mem_addr`, `mem_wdata` and `stall_out` are all 0.
- `stall_out` = (state==WAIT) && !`mem_ready`, combinational. Upstream advances on every edge where `stall_out`=0.
- Non-memory instruction: write-back appears 1 cycle after acceptance.
- Memory instruction:
  - `mem_req` rises 1 cycle after acceptance.
  - Write-back appears 1 cycle after the `mem_ready` cycle.
  - Minimum latency is 2 cycles, for `mem_ready` in the first WAIT cycle.
- `mem_ready` outside WAIT is ignored.
- `write_out` is a 1-cycle pulse per instruction. It is never held across cycles.
- Reset asserted mid-WAIT: the request is abandoned, `mem_req` drops asynchronously and no write-back occurs. The cache must tolerate a dropped request.

## Configuration
- `LOAD_SIGN_EXTEND_EN` defined: byte loads are sign-extended from bit 7.
- `LOAD_SIGN_EXTEND_EN` undefined: byte loads are zero-extended. Word loads and stores are unaffected either way.

## Structure
- Shared package `pa_pkg`:
  - `DATA_W`=32 and `REG_ADDR_W`=5.
  - FSM state typedef `mem_state_t` {IDLE, WAIT}.
  - Lane-select constants.
- Sub-module `load_align`: purely combinational (`rdata`, `addr[1:0]`, byte) -> 32-bit data; holds the macro-dependent extension.
- Top-level `mem_writeback` holds the FSM, capture registers and write-back registers.

## Test plan
- ALU op with result 0x0000_1234 and rd=5: 1 cycle later `write_out`=1, `addr_d_out`=5, `d_out`=0x1234. On the following idle cycle `write_out`=0. `stall_out` stays 0.
- Word load from addr 0x100, `mem_ready` after 3 WAIT cycles, `rdata`=0xDEAD_BEEF, rd=7:
  - `stall_out`=1 for exactly 3 cycles.
  - Write-back rd=7, data 0xDEADBEEF, one pulse.
- Byte load from addr 0x103 with `rdata`=0x80AA_BBCC: `d_out`=0xFFFF_FF80 with `LOAD_SIGN_EXTEND_EN`, 0x0000_0080 without.
- Byte store of `store_data`=0x1234_5678 to addr 0x41: `mem_we`=1, `mem_byte`=1, `mem_wdata`=0x7878_7878, `write_out` never 1.
- Back-to-back: load followed by ALU op held in EX/MEM. The ALU write-back appears exactly 1 cycle after the load write-back, with no duplicate of the load.
- Reset low during WAIT: `mem_req`=0 immediately. After release the FSM is in IDLE, `write_out`=0, and a fresh ALU op completes normally.
